// File: rtl/i8088_bus_pkg.sv
// Shared types and defaults for the 8088 minimum-mode bus initiator.
package i8088_bus_pkg;

  localparam int unsigned CLK_DIV_DEF  = 20;
  localparam int unsigned WAIT_MAX_DEF = 1023;

  typedef enum logic [2:0] {
    S_TI = 3'd0,
    S_T1 = 3'd1,
    S_T2 = 3'd2,
    S_T3 = 3'd3,
    S_TW = 3'd4,
    S_T4 = 3'd5
  } bus_state_e;

  typedef struct packed {
    logic [19:0] addr;
    logic        write;
    logic        io;
    logic [7:0]  wdata;
  } bus_req_t;

endpackage

// File: rtl/i8088_tclk_gen.sv
// T-state tick and 1/3-duty cpu_clk from the system clock, plus the READY synchronizer.
module i8088_tclk_gen
  import i8088_bus_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic ready_i,
  output logic tick_o,
  output logic cpu_clk_o,
  output logic ready_s_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] CPU_HI   = 8'(CLK_DIV / 3);

  logic [7:0] div_cnt_q;
  logic [1:0] ready_sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      div_cnt_q    <= '0;
      ready_sync_q <= '0;
    end else begin
      div_cnt_q    <= (div_cnt_q == DIV_LAST) ? 8'd0 : div_cnt_q + 8'd1;
      ready_sync_q <= {ready_sync_q[0], ready_i};
    end
  end

  assign tick_o    = (div_cnt_q == DIV_LAST);
  assign cpu_clk_o = (div_cnt_q < CPU_HI);
  assign ready_s_o = ready_sync_q[1];

endmodule

// File: rtl/i8088_bus_master.sv
// 8088 minimum-mode bus initiator: turns one request into a T1..T4 (+Tw) bus cycle.
//   state | meaning
//   TI    | idle; request latched when req_ready drops, T1 at next tick
//   T1    | ALE, address on AD and A19..A8, IO/M and DT/R set
//   T2    | strobe asserted, DEN low; read releases AD, write drives data
//   T3/TW | strobe held until synchronized READY or wait timeout
//   T4    | strobes released, response pulsed at the closing tick
module i8088_bus_master
  import i8088_bus_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic        CLK100MHZ,
  input  logic        ck_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [19:0] req_addr,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        cpu_clk,
  output logic [11:0] a_hi,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic [7:0]  ad_in,
  output logic        ale,
  output logic        nrd,
  output logic        nwr,
  output logic        io_nm,
  output logic        dt_nr,
  output logic        nden,
  input  logic        ready
);

  localparam int unsigned WCW = $clog2(WAIT_MAX + 1);

  logic tick;
  logic ready_s;

  i8088_tclk_gen #(.CLK_DIV(CLK_DIV)) u_tclk (
    .clk_i     (CLK100MHZ),
    .rst_n_i   (ck_rst),
    .ready_i   (ready),
    .tick_o    (tick),
    .cpu_clk_o (cpu_clk),
    .ready_s_o (ready_s)
  );

  bus_state_e     state_q;
  bus_req_t       req_q;
  logic [WCW-1:0] wait_cnt_q;
  logic [WCW-1:0] wait_cnt_d;
  logic           timeout_hit;
  logic           leave_wait;

  logic        req_ready_q, rsp_valid_q, rsp_err_q;
  logic [7:0]  rsp_rdata_q, ad_out_q;
  logic [11:0] a_hi_q;
  logic        ad_oe_q, ale_q, nrd_q, nwr_q, io_nm_q, dt_nr_q, nden_q;

  // wait_cnt counts completed Tw states, so WAIT_MAX of them are inserted before abort
  assign wait_cnt_d  = wait_cnt_q + 1'b1;
  assign timeout_hit = (state_q == S_TW) && !ready_s && (wait_cnt_d == WCW'(WAIT_MAX));
  assign leave_wait  = ready_s || timeout_hit;

  always_ff @(posedge CLK100MHZ) begin
    if (!ck_rst) begin
      state_q     <= S_TI;
      req_q       <= '0;
      wait_cnt_q  <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      a_hi_q      <= '0;
      ad_out_q    <= '0;
      ad_oe_q     <= 1'b0;
      ale_q       <= 1'b0;
      nrd_q       <= 1'b1;
      nwr_q       <= 1'b1;
      io_nm_q     <= 1'b0;
      dt_nr_q     <= 1'b1;
      nden_q      <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      if (req_valid && req_ready_q) begin
        req_q       <= '{addr: req_addr, write: req_write, io: req_io, wdata: req_wdata};
        req_ready_q <= 1'b0;
      end
      if (tick) begin
        unique case (state_q)
          S_TI: begin
            // req_ready still high here means nothing was latched before this tick
            if (!req_ready_q) begin
              state_q  <= S_T1;
              ale_q    <= 1'b1;
              ad_oe_q  <= 1'b1;
              ad_out_q <= req_q.addr[7:0];
              a_hi_q   <= req_q.addr[19:8];
              io_nm_q  <= req_q.io;
              dt_nr_q  <= req_q.write;
              nden_q   <= 1'b1;
            end
          end
          S_T1: begin
            state_q <= S_T2;
            ale_q   <= 1'b0;
            nden_q  <= 1'b0;
            if (req_q.write) begin
              ad_out_q <= req_q.wdata;
              nwr_q    <= 1'b0;
            end else begin
              ad_oe_q <= 1'b0;
              nrd_q   <= 1'b0;
            end
          end
          S_T2: state_q <= S_T3;
          S_T3, S_TW: begin
            if (leave_wait) begin
              state_q     <= S_T4;
              nrd_q       <= 1'b1;
              nwr_q       <= 1'b1;
              nden_q      <= 1'b1;
              rsp_err_q   <= timeout_hit;
              rsp_rdata_q <= (req_q.write || timeout_hit) ? 8'h00 : ad_in;
            end else if (state_q == S_T3) begin
              state_q    <= S_TW;
              wait_cnt_q <= '0;
            end else begin
              wait_cnt_q <= wait_cnt_d;
            end
          end
          S_T4: begin
            state_q     <= S_TI;
            ad_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            req_ready_q <= 1'b1;
          end
          default: state_q <= S_TI;
        endcase
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign a_hi      = a_hi_q;
  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign ale       = ale_q;
  assign nrd       = nrd_q;
  assign nwr       = nwr_q;
  assign io_nm     = io_nm_q;
  assign dt_nr     = dt_nr_q;
  assign nden      = nden_q;

endmodule

// File: tb/tb_i8088_bus_master.sv
// Scoreboard bench for i8088_bus_master: CLK_DIV=20, WAIT_MAX=4.
module tb_i8088_bus_master;

  logic        clk = 1'b0;
  logic        ck_rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [19:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic        req_io = 1'b0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        cpu_clk;
  logic [11:0] a_hi;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [7:0]  ad_in;
  logic        ale, nrd, nwr, io_nm, dt_nr, nden;
  logic        ready = 1'b1;
  logic [7:0]  slave_data = 8'h00;

  always #5 clk = ~clk;

  // slave model: drives data only while the read strobe is low and it is ready
  assign ad_in = (!nrd && ready) ? slave_data : 8'hFF;

  i8088_bus_master #(.CLK_DIV(20), .WAIT_MAX(4)) dut (
    .CLK100MHZ (clk),
    .ck_rst    (ck_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_io    (req_io),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .cpu_clk   (cpu_clk),
    .a_hi      (a_hi),
    .ad_out    (ad_out),
    .ad_oe     (ad_oe),
    .ad_in     (ad_in),
    .ale       (ale),
    .nrd       (nrd),
    .nwr       (nwr),
    .io_nm     (io_nm),
    .dt_nr     (dt_nr),
    .nden      (nden),
    .ready     (ready)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // per-cycle bus observations, restarted at every ALE rising edge
  logic       ale_p = 1'b0, nwr_p = 1'b1, io_at_t1 = 1'b0;
  logic [7:0] ad_t1 = '0, ad_t2 = '0, ad_t4 = '0;
  int t1_cyc = 0, rsp_cyc = 0, rsp_cnt = 0, bad_bus = 0;
  int ale_cnt = 0, nwr_cnt = 0, nrd_cnt = 0, nden_cnt = 0, oe_cnt = 0, io_chg = 0;

  always @(negedge clk) begin
    if (ale && !ale_p) begin
      t1_cyc = cyc; ale_cnt = 0; nwr_cnt = 0; nrd_cnt = 0; nden_cnt = 0;
      oe_cnt = 0; io_chg = 0; ad_t1 = ad_out; io_at_t1 = io_nm;
    end
    if (ale) ale_cnt++;
    if (!nwr) nwr_cnt++;
    if (!nrd) nrd_cnt++;
    if (!nden) nden_cnt++;
    if (ad_oe) oe_cnt++;
    if (io_nm !== io_at_t1) io_chg++;
    if (!nwr && nwr_p) ad_t2 = ad_out;
    if (nwr && !nwr_p) ad_t4 = ad_out;
    if ((!nrd && ad_oe) || (!nrd && !nwr)) bad_bus++;
    if (rsp_valid) begin rsp_cnt++; rsp_cyc = cyc; end
    ale_p = ale;
    nwr_p = nwr;
  end

  task automatic issue(input logic [19:0] a, input logic w, input logic io, input logic [7:0] d);
    int n = 0;
    while (!req_ready && n < 1000) begin @(negedge clk); n++; end
    req_addr = a; req_write = w; req_io = io; req_wdata = d; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic pop_exp(output exp_t e, output bit have);
    have = (exp_q.size() != 0);
    e = '{8'h00, 1'b0};
    if (have) e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    ck_rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ale, nrd, nwr, nden, dt_nr, io_nm, ad_oe} !== 7'b0111100) begin
      errors++; $display("FAIL reset_ctl got %b want 0111100", {ale, nrd, nwr, nden, dt_nr, io_nm, ad_oe});
    end
    checks++;
    if ({ad_out, a_hi} !== 20'h0) begin
      errors++; $display("FAIL reset_addr got %h want 00000", {ad_out, a_hi});
    end
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== 11'b1_0_00000000_0) begin
      errors++; $display("FAIL reset_rsp got %b want 10000000000", {req_ready, rsp_valid, rsp_rdata, rsp_err});
    end
  endtask

  task automatic test_tick();
    int hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cpu_clk) hi++;
    end
    checks++;
    if (hi != 30) begin errors++; $display("FAIL cpu_clk_duty got %0d want 30", hi); end
  endtask

  task automatic test_mem_write();
    bit ok, have;
    exp_t e;
    exp_q.push_back('{8'h00, 1'b0});
    issue(20'h00008, 1'b1, 1'b0, 8'hA5);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_drop got %b want 0", req_ready); end
    wait_rsp(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_timeout got none want rsp_valid"); end
    checks++;
    if (rsp_cyc - t1_cyc != 80) begin errors++; $display("FAIL wr_latency got %0d want 80", rsp_cyc - t1_cyc); end
    checks++;
    if (ale_cnt != 20) begin errors++; $display("FAIL wr_ale_len got %0d want 20", ale_cnt); end
    checks++;
    if ({ad_t1, ad_t2, ad_t4} !== 24'h08A5A5) begin
      errors++; $display("FAIL wr_ad got %h want 08a5a5", {ad_t1, ad_t2, ad_t4});
    end
    checks++;
    if (nwr_cnt != 40) begin errors++; $display("FAIL wr_nwr_len got %0d want 40", nwr_cnt); end
    checks++;
    if (oe_cnt != 80) begin errors++; $display("FAIL wr_oe_len got %0d want 80", oe_cnt); end
    checks++;
    if ({io_at_t1, io_nm, dt_nr, io_chg} !== {1'b0, 1'b0, 1'b1, 32'd0}) begin
      errors++; $display("FAIL wr_dir got io=%b dt=%b chg=%0d want io=0 dt=1 chg=0", io_nm, dt_nr, io_chg);
    end
    pop_exp(e, have);
    checks++;
    if (!have || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++; $display("FAIL wr_rsp got rdata=%h err=%b want rdata=%h err=%b", rsp_rdata, rsp_err, e.rdata, e.err);
    end
  endtask

  task automatic test_io_write();
    bit ok, have;
    exp_t e;
    exp_q.push_back('{8'h00, 1'b0});
    issue(20'h00080, 1'b1, 1'b1, 8'h03);
    wait_rsp(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL io_timeout got none want rsp_valid"); end
    checks++;
    if ({io_at_t1, io_chg} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL io_nm got t1=%b chg=%0d want t1=1 chg=0", io_at_t1, io_chg);
    end
    checks++;
    if ({a_hi, ad_t1, ad_t2} !== 28'h0008003) begin
      errors++; $display("FAIL io_addr got %h want 0008003", {a_hi, ad_t1, ad_t2});
    end
    checks++;
    if (nrd_cnt != 0) begin errors++; $display("FAIL io_nrd_idle got %0d want 0", nrd_cnt); end
    pop_exp(e, have);
    checks++;
    if (!have || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++; $display("FAIL io_rsp got rdata=%h err=%b want rdata=%h err=%b", rsp_rdata, rsp_err, e.rdata, e.err);
    end
  endtask

  task automatic test_mem_read();
    bit ok, have;
    exp_t e;
    slave_data = 8'h5A;
    exp_q.push_back('{8'h5A, 1'b0});
    issue(20'h00000, 1'b0, 1'b0, 8'h00);
    wait_rsp(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_timeout got none want rsp_valid"); end
    checks++;
    if ({nrd_cnt, nden_cnt, oe_cnt} !== {32'd40, 32'd40, 32'd20}) begin
      errors++; $display("FAIL rd_strobes got nrd=%0d nden=%0d oe=%0d want 40 40 20", nrd_cnt, nden_cnt, oe_cnt);
    end
    checks++;
    if (bad_bus != 0) begin errors++; $display("FAIL rd_contention got %0d want 0", bad_bus); end
    checks++;
    if ({dt_nr, io_nm} !== 2'b00) begin errors++; $display("FAIL rd_dir got %b want 00", {dt_nr, io_nm}); end
    pop_exp(e, have);
    checks++;
    if (!have || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++; $display("FAIL rd_rsp got rdata=%h err=%b want rdata=%h err=%b", rsp_rdata, rsp_err, e.rdata, e.err);
    end
  endtask

  task automatic test_wait_states();
    bit ok, have;
    exp_t e;
    int n = 0;
    ready = 1'b0;
    slave_data = 8'hC3;
    exp_q.push_back('{8'hC3, 1'b0});
    issue(20'h4A0F1, 1'b0, 1'b0, 8'h00);
    while (nrd && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (nrd !== 1'b0) begin errors++; $display("FAIL ws_t2 got nrd=%b want 0", nrd); end
    repeat (80) @(negedge clk);
    ready = 1'b1;
    wait_rsp(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ws_timeout got none want rsp_valid"); end
    checks++;
    if (rsp_cyc - t1_cyc != 140) begin errors++; $display("FAIL ws_latency got %0d want 140", rsp_cyc - t1_cyc); end
    checks++;
    if (nrd_cnt != 100) begin errors++; $display("FAIL ws_nrd_len got %0d want 100", nrd_cnt); end
    pop_exp(e, have);
    checks++;
    if (!have || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++; $display("FAIL ws_rsp got rdata=%h err=%b want rdata=%h err=%b", rsp_rdata, rsp_err, e.rdata, e.err);
    end
  endtask

  task automatic test_timeout();
    bit ok, have;
    exp_t e;
    ready = 1'b0;
    slave_data = 8'h77;
    exp_q.push_back('{8'h00, 1'b1});
    issue(20'h12345, 1'b0, 1'b1, 8'h00);
    wait_rsp(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_timeout got none want rsp_valid"); end
    checks++;
    if (rsp_cyc - t1_cyc != 160) begin errors++; $display("FAIL to_latency got %0d want 160", rsp_cyc - t1_cyc); end
    checks++;
    if (nrd_cnt != 120) begin errors++; $display("FAIL to_nrd_len got %0d want 120", nrd_cnt); end
    checks++;
    if ({nrd, nwr, nden} !== 3'b111) begin errors++; $display("FAIL to_strobes got %b want 111", {nrd, nwr, nden}); end
    pop_exp(e, have);
    checks++;
    if (!have || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++; $display("FAIL to_rsp got rdata=%h err=%b want rdata=%h err=%b", rsp_rdata, rsp_err, e.rdata, e.err);
    end
    ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok, have;
    exp_t e;
    int n = 0;
    int rsp_before;
    issue(20'h00100, 1'b1, 1'b0, 8'h3C);
    while (nwr && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (nwr !== 1'b0) begin errors++; $display("FAIL rm_t2 got nwr=%b want 0", nwr); end
    rsp_before = rsp_cnt;
    ck_rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({nwr, ad_oe, ale, req_ready, nden} !== 5'b10011) begin
      errors++; $display("FAIL rm_outputs got %b want 10011", {nwr, ad_oe, ale, req_ready, nden});
    end
    @(negedge clk);
    ck_rst = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (rsp_cnt != rsp_before) begin errors++; $display("FAIL rm_no_rsp got %0d want %0d", rsp_cnt, rsp_before); end
    exp_q.push_back('{8'h00, 1'b0});
    issue(20'h00200, 1'b1, 1'b0, 8'hE7);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_cyc - t1_cyc != 80) begin
      errors++; $display("FAIL rm_after got ok=%b lat=%0d want ok=1 lat=80", ok, rsp_cyc - t1_cyc);
    end
    pop_exp(e, have);
    checks++;
    if (!have || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++; $display("FAIL rm_rsp got rdata=%h err=%b want rdata=%h err=%b", rsp_rdata, rsp_err, e.rdata, e.err);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, have;
    exp_t e;
    int r1;
    slave_data = 8'h96;
    exp_q.push_back('{8'h00, 1'b0});
    exp_q.push_back('{8'h96, 1'b0});
    issue(20'h0F00F, 1'b1, 1'b0, 8'h11);
    wait_rsp(ok);
    r1 = rsp_cyc;
    pop_exp(e, have);
    checks++;
    if (!ok || !have || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++; $display("FAIL b2b_first got ok=%b rdata=%h err=%b want rdata=%h err=%b", ok, rsp_rdata, rsp_err, e.rdata, e.err);
    end
    issue(20'h0F010, 1'b0, 1'b0, 8'h00);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_cyc - r1 != 100) begin
      errors++; $display("FAIL b2b_spacing got ok=%b gap=%0d want gap=100", ok, rsp_cyc - r1);
    end
    pop_exp(e, have);
    checks++;
    if (!have || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++; $display("FAIL b2b_second got rdata=%h err=%b want rdata=%h err=%b", rsp_rdata, rsp_err, e.rdata, e.err);
    end
    checks++;
    if (bad_bus != 0) begin errors++; $display("FAIL bus_rules got %0d want 0", bad_bus); end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_mem_write();
    test_io_write();
    test_mem_read();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
